// File: rtl/ex_mem_pkg.sv
// Shared types and default widths for the EX/MEM pipeline stage buffer.
package ex_mem_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int M_W    = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WB_W-1:0]   wb_ctl;
        logic [M_W-1:0]    m_ctl;
        logic [DATA_W-1:0] add_result;
        logic              zero;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] rdata2;
        logic [REG_W-1:0]  dest;
    } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_entry.sv
// One payload register of the EX/MEM buffer: load enable, input/skid source
// select and synchronous clear.
module ex_mem_entry
    import ex_mem_pkg::*;
#(
    parameter type payload_t = ex_mem_payload_t
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     load,
    input  logic     sel_skid,
    input  payload_t in_data,
    input  payload_t skid_data,
    output payload_t q
);

    // NOTE: the payload is reset (not just the valid bit) so every output
    // reads 0 after reset, and sequential state uses non-blocking updates.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (load) begin
            q <= sel_skid ? skid_data : in_data;
        end
    end

endmodule

// File: rtl/ex_mem_stage_buffer.sv
// EX/MEM pipeline stage with valid/ready handshake, flush and bubble gating.
// Define EXMEM_SKID_EN for a two-entry skid buffer with registered in_ready.
module ex_mem_stage_buffer #(
    parameter int DATA_W = ex_mem_pkg::DATA_W,
    parameter int REG_W  = ex_mem_pkg::REG_W,
    parameter int WB_W   = ex_mem_pkg::WB_W,
    parameter int M_W    = ex_mem_pkg::M_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_wb_ctl,
    input  logic [M_W-1:0]    in_m_ctl,
    input  logic [DATA_W-1:0] in_add_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_rdata2,
    input  logic [REG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb_ctl,
    output logic [M_W-1:0]    out_m_ctl,
    output logic [DATA_W-1:0] out_add_result,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_rdata2,
    output logic [REG_W-1:0]  out_dest,
    output logic [1:0]        occupancy
);

    import ex_mem_pkg::*;

    typedef struct packed {
        logic [WB_W-1:0]   wb_ctl;
        logic [M_W-1:0]    m_ctl;
        logic [DATA_W-1:0] add_result;
        logic              zero;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] rdata2;
        logic [REG_W-1:0]  dest;
    } payload_t;

    state_t   state, state_next;
    payload_t in_pl, main_q, skid_q;
    logic     in_fire, out_fire;
    logic     main_load, main_sel_skid, skid_load;

    assign in_pl = '{wb_ctl:     in_wb_ctl,
                     m_ctl:      in_m_ctl,
                     add_result: in_add_result,
                     zero:       in_zero,
                     alu_result: in_alu_result,
                     rdata2:     in_rdata2,
                     dest:       in_dest};

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef EXMEM_SKID_EN
    // Decoded straight from the state flops: no path from out_ready.
    assign in_ready = (state != TWO);
`else
    assign in_ready = !out_valid | out_ready;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        main_load     = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_load  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
`ifdef EXMEM_SKID_EN
                    else if (in_fire) begin
                        skid_load  = 1'b1;
                        state_next = TWO;
                    end
`endif
                end
`ifdef EXMEM_SKID_EN
                TWO: begin
                    if (out_fire) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        state_next    = ONE;
                    end
                end
`endif
                default: state_next = EMPTY;
            endcase
        end
    end

    ex_mem_entry #(.payload_t(payload_t)) u_main (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .load      (main_load),
        .sel_skid  (main_sel_skid),
        .in_data   (in_pl),
        .skid_data (skid_q),
        .q         (main_q)
    );

`ifdef EXMEM_SKID_EN
    ex_mem_entry #(.payload_t(payload_t)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .load      (skid_load),
        .sel_skid  (1'b0),
        .in_data   (in_pl),
        .skid_data ('0),
        .q         (skid_q)
    );
`else
    assign skid_q = '0;
`endif

    // Bubble gating: control fields never leak from an empty stage.
    assign out_wb_ctl     = out_valid ? main_q.wb_ctl : '0;
    assign out_m_ctl      = out_valid ? main_q.m_ctl  : '0;
    assign out_add_result = main_q.add_result;
    assign out_zero       = main_q.zero;
    assign out_alu_result = main_q.alu_result;
    assign out_rdata2     = main_q.rdata2;
    assign out_dest       = main_q.dest;

    always_comb begin
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
// Directed self-checking bench for ex_mem_stage_buffer (either build of EXMEM_SKID_EN).
module tb_ex_mem_stage_buffer;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_wb_ctl, out_wb_ctl, occupancy;
    logic [2:0]  in_m_ctl, out_m_ctl;
    logic [31:0] in_add_result, in_alu_result, in_rdata2;
    logic [31:0] out_add_result, out_alu_result, out_rdata2;
    logic        in_zero, out_zero;
    logic [4:0]  in_dest, out_dest;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_stage_buffer dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_ctl(in_wb_ctl), .in_m_ctl(in_m_ctl), .in_add_result(in_add_result),
        .in_zero(in_zero), .in_alu_result(in_alu_result), .in_rdata2(in_rdata2),
        .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_ctl(out_wb_ctl), .out_m_ctl(out_m_ctl), .out_add_result(out_add_result),
        .out_zero(out_zero), .out_alu_result(out_alu_result), .out_rdata2(out_rdata2),
        .out_dest(out_dest), .occupancy(occupancy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Derived fields make every payload field checkable from alu alone.
    task automatic set_in(input logic v, input logic [31:0] alu,
                          input logic [2:0] m, input logic [1:0] wb);
        in_valid      = v;
        in_alu_result = alu;
        in_add_result = alu + 32'h100;
        in_rdata2     = ~alu;
        in_dest       = alu[4:0];
        in_zero       = (alu == 32'd0);
        in_m_ctl      = m;
        in_wb_ctl     = wb;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b1, 32'hDEAD_BEEF, 3'b111, 2'b11);
        for (int c = 0; c < 2; c++) begin
            tick;
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", c, out_valid); end
            n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
            n_cmp++; if ({out_wb_ctl, out_m_ctl, out_zero, out_dest} !== 11'd0) begin n_bad++; $display("FAIL reset_ctl got=%h exp=0", {out_wb_ctl, out_m_ctl, out_zero, out_dest}); end
            n_cmp++; if ({out_alu_result, out_add_result, out_rdata2} !== 96'd0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", {out_alu_result, out_add_result, out_rdata2}); end
        end
        reset = 1'b0;
        set_in(1'b0, 32'd0, 3'b000, 2'b00);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_streaming;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'(i), 3'(i), 2'(i));
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
            tick;
            n_cmp++; if (out_valid !== 1'b1 || out_alu_result !== 32'(i)) begin n_bad++; $display("FAIL stream_out i=%0d got v=%b alu=%0d exp v=1 alu=%0d", i, out_valid, out_alu_result, i); end
            n_cmp++; if (out_add_result !== 32'(i) + 32'h100 || out_rdata2 !== ~32'(i) || out_dest !== 5'(i) || out_zero !== (i == 0)) begin n_bad++; $display("FAIL stream_fields i=%0d got add=%h rd2=%h dest=%0d z=%b", i, out_add_result, out_rdata2, out_dest, out_zero); end
            n_cmp++; if (out_m_ctl !== 3'(i) || out_wb_ctl !== 2'(i) || occupancy !== 2'd1) begin n_bad++; $display("FAIL stream_ctl i=%0d got m=%0d wb=%0d occ=%0d", i, out_m_ctl, out_wb_ctl, occupancy); end
        end
        set_in(1'b0, 32'd0, 3'b000, 2'b00);
        tick;
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_bad++; $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_back_pressure;
        out_ready = 1'b0;
        set_in(1'b1, 32'h10, 3'b001, 2'b01);
        tick;
        set_in(1'b1, 32'h20, 3'b010, 2'b10);
`ifdef EXMEM_SKID_EN
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
`else
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_one got=%b exp=0", in_ready); end
`endif
        tick;
        set_in(1'b0, 32'd0, 3'b000, 2'b00);
`ifdef EXMEM_SKID_EN
        n_cmp++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin n_bad++; $display("FAIL bp_full got rdy=%b occ=%0d exp rdy=0 occ=2", in_ready, occupancy); end
`else
        n_cmp++; if (in_ready !== 1'b0 || occupancy !== 2'd1) begin n_bad++; $display("FAIL bp_full got rdy=%b occ=%0d exp rdy=0 occ=1", in_ready, occupancy); end
`endif
        n_cmp++; if (out_valid !== 1'b1 || out_alu_result !== 32'h10 || out_m_ctl !== 3'b001) begin n_bad++; $display("FAIL bp_hold_a got v=%b alu=%h m=%0d exp v=1 alu=10 m=1", out_valid, out_alu_result, out_m_ctl); end
        out_ready = 1'b1;
        tick;
`ifdef EXMEM_SKID_EN
        n_cmp++; if (out_valid !== 1'b1 || out_alu_result !== 32'h20 || out_m_ctl !== 3'b010 || occupancy !== 2'd1) begin n_bad++; $display("FAIL bp_b got v=%b alu=%h m=%0d occ=%0d exp v=1 alu=20 m=2 occ=1", out_valid, out_alu_result, out_m_ctl, occupancy); end
        tick;
`endif
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_bad++; $display("FAIL bp_drained got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        set_in(1'b1, 32'h30, 3'b011, 2'b01);
        tick;
        set_in(1'b1, 32'h40, 3'b100, 2'b10);
        tick;
        flush = 1'b1;
        set_in(1'b1, 32'h50, 3'b111, 2'b11);
        tick;
        flush = 1'b0;
        set_in(1'b0, 32'd0, 3'b000, 2'b00);
        n_cmp++; if (out_valid !== 1'b0 || out_m_ctl !== 3'd0 || out_wb_ctl !== 2'd0) begin n_bad++; $display("FAIL flush_out got v=%b m=%0d wb=%0d exp 0 0 0", out_valid, out_m_ctl, out_wb_ctl); end
        n_cmp++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_state got occ=%0d rdy=%b exp occ=0 rdy=1", occupancy, in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_c_leak cyc=%0d got v=%b alu=%h exp v=0", c, out_valid, out_alu_result); end
        end
    endtask

    task automatic test_bubble;
        out_ready = 1'b1;
        set_in(1'b1, 32'h77, 3'b101, 2'b10);
        tick;
        n_cmp++; if (out_valid !== 1'b1 || out_m_ctl !== 3'b101 || out_wb_ctl !== 2'b10) begin n_bad++; $display("FAIL bubble_live got v=%b m=%b wb=%b exp 1 101 10", out_valid, out_m_ctl, out_wb_ctl); end
        set_in(1'b0, 32'h99, 3'b111, 2'b11);
        tick;
        n_cmp++; if (out_valid !== 1'b0 || out_m_ctl !== 3'b000 || out_wb_ctl !== 2'b00) begin n_bad++; $display("FAIL bubble_gate got v=%b m=%b wb=%b exp 0 000 00", out_valid, out_m_ctl, out_wb_ctl); end
        n_cmp++; if (out_alu_result !== 32'h77) begin n_bad++; $display("FAIL bubble_hold got alu=%h exp alu=77", out_alu_result); end
    endtask

    task automatic test_simultaneous;
        out_ready = 1'b1;
        set_in(1'b1, 32'hA0, 3'b000, 2'b00);
        tick;
        for (int i = 1; i < 6; i++) begin
            set_in(1'b1, 32'hA0 + 32'(i), 3'(i), 2'(i));
            tick;
            n_cmp++; if (occupancy !== 2'd1 || out_alu_result !== 32'hA0 + 32'(i) || out_m_ctl !== 3'(i)) begin n_bad++; $display("FAIL simul i=%0d got occ=%0d alu=%h m=%0d exp occ=1 alu=%h m=%0d", i, occupancy, out_alu_result, out_m_ctl, 32'hA0 + 32'(i), i); end
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        set_in(1'b1, 32'hC0, 3'b110, 2'b01);
        tick;
        reset = 1'b1;
        flush = 1'b1;
        tick;
        reset = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 32'd0, 3'b000, 2'b00);
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_alu_result !== 32'd0 || out_m_ctl !== 3'd0) begin n_bad++; $display("FAIL reset_mid got v=%b occ=%0d alu=%h m=%0d exp all 0", out_valid, occupancy, out_alu_result, out_m_ctl); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_back_pressure;
        test_flush;
        test_bubble;
        test_simultaneous;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage_buffer.md
# ex_mem_stage_buffer

Parametrised execute-to-memory pipeline stage with a valid/ready handshake, flush, and bubble gating. Sits between the ALU/branch-adder stage and the data-memory stage. It generalises the plain EX/MEM latch with configurable field widths, back-pressure from the memory stage, and an optional two-entry skid buffer for full throughput with a registered `in_ready`.

## Interface
- `DATA_W`, 32, width of ALU result, branch target, and store data
- `REG_W`, 5, width of destination register index
- `WB_W`, 2, width of write-back control field
- `M_W`, 3, width of memory control field
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  kill all held entries and the incoming transaction this cycle
- `in_valid`  in  1  execute stage presents a transaction
- `in_ready`  out  1  buffer accepts a transaction this cycle
- `in_wb_ctl`  in  WB_W  write-back control
- `in_m_ctl`  in  M_W  memory control
- `in_add_result`  in  DATA_W  branch target
- `in_zero`  in  1  ALU zero flag
- `in_alu_result`  in  DATA_W  ALU result / memory address
- `in_rdata2`  in  DATA_W  store data
- `in_dest`  in  REG_W  destination register
- `out_valid`  out  1  memory stage has a valid transaction
- `out_ready`  in  1  memory stage consumes the transaction
- `out_wb_ctl`, `out_m_ctl`, `out_add_result`, `out_zero`, `out_alu_result`, `out_rdata2`, `out_dest`  out  matching widths  held transaction
- `occupancy`  out  2  number of held entries (0..2)

## Operation
- A transfer happens on the input side when `in_valid & in_ready`. It happens on the output side when `out_valid & out_ready`.
- Bubble gating: when `out_valid=0`, `out_wb_ctl` and `out_m_ctl` are driven 0. No register write or memory access can leak from a bubble. The data fields hold their last value.
- The skid-variant state machine has three states: EMPTY, ONE (main entry valid), and TWO (main and skid entries valid).
- EMPTY:
  - `in_valid` loads main → ONE.
- ONE:
  - input and output transfer together: main is replaced, stay in ONE.
  - input only: load skid → TWO.
  - output only → EMPTY.
- TWO:
  - `in_ready=0`.
  - output transfer: main is loaded from skid → ONE.
- `in_ready` is registered as `state != TWO`. It has no combinational path from `out_ready`.
- `out_valid = (state != EMPTY)`. Outputs always show the main entry.
- `occupancy`: EMPTY=0, ONE=1, TWO=2.
- Flush has priority over every other event. Next state is EMPTY, and the input transaction in the same cycle is discarded even if `in_valid & in_ready`. `out_valid` drops the next cycle.
- Reset has priority over flush. State EMPTY, all outputs 0, `in_ready=1` on the cycle after reset.
- Reset mid-transfer: held entries are discarded with no partial output.

## Timing
- Latency: an accepted input appears on the outputs 1 cycle later. Throughput is 1 transaction per cycle while `out_ready=1`.
- `out_*` change only on a clock edge.
- With `out_ready=0` held, at most 2 transactions are accepted. `in_ready` falls on the edge that fills the skid entry.
- After reset, every output is 0, including `out_zero`, `out_dest`, and `occupancy`.

## Configuration
- `EXMEM_SKID_EN` defined: two-entry skid buffer as described above.
- Not defined:
  - Single entry only; state is EMPTY or ONE.
  - `in_ready = !out_valid | out_ready`, a combinational path.
  - `occupancy` never exceeds 1.
  - Latency 1, throughput 1/cycle; a stalled buffer holds exactly one transaction.
- Flush, reset, and bubble gating are identical in both builds.

## Structure
- Shared package `ex_mem_pkg`:
  - default width constants `DATA_W`, `REG_W`, `WB_W`, `M_W`
  - payload struct type with the seven fields
  - state enum `{EMPTY, ONE, TWO}`
- One sub-module, `ex_mem_entry`: a payload register with load enable, a selectable source (input or skid), and synchronous clear. It is instantiated once for main and once for skid (skid only under `EXMEM_SKID_EN`).

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid=1` → all outputs 0, `occupancy=0`; `in_ready=1` the cycle after release.
- Streaming: `out_ready=1`, 8 back-to-back inputs with `in_alu_result` 0..7 → outputs 0..7 on consecutive cycles, each 1 cycle after acceptance, no gaps.
- Back-pressure: `out_ready=0`, inputs A=0x10 and B=0x20 → `in_ready=0` after B, `occupancy=2`. Release `out_ready` → A then B, in order, no loss or duplication. Without `EXMEM_SKID_EN`, only A is accepted and `occupancy` stays at 1.
- Flush: `occupancy=2` with `flush=1` and a simultaneous valid input C → next cycle `out_valid=0`, `out_m_ctl=0`, `out_wb_ctl=0`; C never appears.
- Bubble gating: input with `in_m_ctl=3'b101` consumed, then `in_valid=0` → `out_m_ctl=0` and `out_wb_ctl=0` while `out_alu_result` holds its last value.
- Simultaneous transfer in ONE: `in_valid=1` and `out_ready=1` every cycle → `occupancy` stays 1 and the outputs track the inputs with 1-cycle delay.
